// File: rtl/blink_detector.sv
// Blink receiver: synchronizes an asynchronous blink line, measures edge-to-edge
// spacing, locks when it matches the expected half-period and flags a stuck line.
module blink_detector #(
   parameter int CLK_IN   = 300,
   parameter int FREQ_OUT = 5,
   parameter int TOL      = 1,
   parameter int LOCK_CNT = 4,
   parameter int CNT_W    = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_en,
   input  logic             i_blink,
   output logic [CNT_W-1:0] o_half_period,
   output logic             o_valid,
   output logic             o_locked,
   output logic             o_stuck
);

   localparam int EXPECTED = CLK_IN / (2 * FREQ_OUT);
   localparam int TIMEOUT  = 4 * EXPECTED;
   localparam int MW       = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXPECTED);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TIMEOUT - 1);
   localparam logic [MW-1:0]    LOCK_C    = MW'(LOCK_CNT);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } state_t;

   state_t           state_q;
   logic             s1_q, s2_q, s3_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [MW-1:0]    match_q, match_inc;
   logic             edge_w, in_tol_w, timeout_w;
   logic [CNT_W-1:0] h_w, diff_w;

   // Larger-minus-smaller keeps the distance unsigned with no wrap.
   always_comb begin
      edge_w    = s2_q ^ s3_q;
      h_w       = cnt_q + CNT_W'(1);
      diff_w    = (h_w >= EXP_C) ? (h_w - EXP_C) : (EXP_C - h_w);
      in_tol_w  = (diff_w <= TOL_C);
      timeout_w = (cnt_q == TO_LAST_C);
      match_inc = (match_q == LOCK_C) ? match_q : (match_q + MW'(1));
      cnt_d     = cnt_q;
      if (edge_w)          cnt_d = '0;
      else if (!timeout_w) cnt_d = cnt_q + CNT_W'(1);
   end

   // NOTE: all state and outputs update with non-blocking assignments so every
   // read in this block sees the pre-edge value, independent of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q       <= IDLE;
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         cnt_q         <= '0;
         match_q       <= '0;
         o_half_period <= '0;
         o_valid       <= 1'b0;
         o_locked      <= 1'b0;
         o_stuck       <= 1'b0;
      end else begin
         s1_q <= i_blink;
         s2_q <= s1_q;
         s3_q <= s2_q;
         // NOTE: default-low each cycle turns o_valid into a single-cycle pulse.
         o_valid <= 1'b0;
         if (!i_en) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            match_q  <= '0;
            o_locked <= 1'b0;
            o_stuck  <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            if (edge_w) o_stuck <= 1'b0;
            case (state_q)
               IDLE: begin
                  if (edge_w) state_q <= MEASURE;
               end
               MEASURE, LOCKED: begin
                  if (edge_w) begin
                     o_half_period <= h_w;
                     o_valid       <= 1'b1;
                     if (in_tol_w) begin
                        match_q <= match_inc;
                        if (state_q == MEASURE && match_inc == LOCK_C) begin
                           state_q  <= LOCKED;
                           o_locked <= 1'b1;
                        end
                     end else begin
                        match_q  <= '0;
                        state_q  <= MEASURE;
                        o_locked <= 1'b0;
                     end
                  end else if (timeout_w) begin
                     state_q  <= IDLE;
                     match_q  <= '0;
                     o_locked <= 1'b0;
                     o_stuck  <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blink_detector.sv
// Scoreboard bench for blink_detector: stimulus pushes expected captures, a
// negedge monitor pops and compares them whenever o_valid pulses.
module tb_blink_detector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        blink;
   logic [31:0] half_period;
   logic        valid, locked, stuck;

   typedef struct {
      logic [31:0] half;
      logic        locked;
      logic        stuck;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   blink_detector dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_en          (en),
      .i_blink       (blink),
      .o_half_period (half_period),
      .o_valid       (valid),
      .o_locked      (locked),
      .o_stuck       (stuck)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int h, input logic lk);
      exp_t e;
      e.half   = h;
      e.locked = lk;
      e.stuck  = 1'b0;
      sb.push_back(e);
   endtask

   // Toggle the line n clocks after the previous toggle/step point.
   task automatic toggle_after(input int n);
      repeat (n) @(posedge clk);
      #1 blink = ~blink;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic good_lock_run();
      for (int i = 0; i < 4; i++) begin
         push(30, i == 3);
         toggle_after(30);
      end
   endtask

   // Monitor: every o_valid pulse must match the oldest expected capture.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_valid", valid, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_half_period", half_period, e.half);
            check("sb_locked", locked, e.locked);
            check("sb_stuck", stuck, e.stuck);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      blink = 1'b0;
      wait_cycles(3);
      check("rst_half_period", half_period, 0);
      check("rst_valid", valid, 0);
      check("rst_locked", locked, 0);
      check("rst_stuck", stuck, 0);
      rst_n = 1'b1;

      // Clean lock: first edge uncaptured, lock on the 5th edge.
      toggle_after(5);
      good_lock_run();

      // Tolerance: 32 drops lock, then 29/31/30/29 relock, 31 keeps it.
      push(32, 1'b0);
      toggle_after(32);
      push(29, 1'b0); toggle_after(29);
      push(31, 1'b0); toggle_after(31);
      push(30, 1'b0); toggle_after(30);
      push(29, 1'b1); toggle_after(29);
      push(31, 1'b1); toggle_after(31);

      // Stuck line: edge lands 2 clocks after the toggle, timeout 120 after that.
      wait_cycles(122);
      check("stuck_before_to", stuck, 0);
      check("locked_before_to", locked, 1);
      wait_cycles(1);
      check("stuck_at_to", stuck, 1);
      check("locked_at_to", locked, 0);

      // Next toggle clears o_stuck without a capture.
      toggle_after(1);
      wait_cycles(2);
      check("stuck_hold", stuck, 1);
      wait_cycles(1);
      check("stuck_cleared", stuck, 0);

      // Edge exactly at the timeout point wins (3 clocks already elapsed).
      push(120, 1'b0);
      toggle_after(117);
      // Spacing of 121: timeout fires first.
      wait_cycles(122);
      check("stuck_121_before", stuck, 0);
      wait_cycles(1);
      check("stuck_121_at_to", stuck, 1);

      // Uncaptured edge out of IDLE, then relock for the reset test.
      toggle_after(1);
      good_lock_run();
      wait_cycles(5);
      check("pre_reset_locked", locked, 1);
      rst_n = 1'b0;
      blink = 1'b0;
      wait_cycles(1);
      check("midrst_half_period", half_period, 0);
      check("midrst_valid", valid, 0);
      check("midrst_locked", locked, 0);
      check("midrst_stuck", stuck, 0);
      rst_n = 1'b1;
      toggle_after(4);
      good_lock_run();

      // Enable gating: lock drops, measurement holds, synchronizer keeps running.
      wait_cycles(5);
      en = 1'b0;
      wait_cycles(1);
      check("dis_locked", locked, 0);
      check("dis_half_period", half_period, 30);
      check("dis_stuck", stuck, 0);
      toggle_after(3);
      wait_cycles(10);
      check("dis_hold_half", half_period, 30);
      check("dis_no_valid", valid, 0);
      en = 1'b1;
      toggle_after(5);
      good_lock_run();

      wait_cycles(10);
      check("sb_drained", sb.size(), 0);
      check("final_locked", locked, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
